// File: rtl/lsu_mem_master.sv
// Multicycle load/store unit: one word-wide bus request per op, byte-lane steering and load extension.
// Define LSU_TIMEOUT_EN to enable the BUS-state wait timeout (exc_bus).
module lsu_mem_master #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic        op_wr,
   input  logic [3:0]  op_ctrl,
   input  logic [31:0] op_addr,
   input  logic [31:0] op_wdata,
   output logic        done,
   output logic [31:0] ld_data,
   output logic        exc_adel,
   output logic        exc_ades,
   output logic        exc_bus,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam logic [3:0] MEM_LB  = 4'h0;
   localparam logic [3:0] MEM_LH  = 4'h1;
   localparam logic [3:0] MEM_LW  = 4'h2;
   localparam logic [3:0] MEM_LBU = 4'h4;
   localparam logic [3:0] MEM_LHU = 4'h5;
   localparam logic [3:0] MEM_SB  = 4'h8;
   localparam logic [3:0] MEM_SH  = 4'h9;
   localparam logic [3:0] MEM_SW  = 4'hA;

   // The wait counter is 8 bits wide, so TIMEOUT must lie in 1..256.
   if (TIMEOUT < 1 || TIMEOUT > 256) begin : g_timeout_range
      $error("lsu_mem_master: TIMEOUT out of range");
   end

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

   state_t      state;
   size_t       size_q;
   logic        sign_q;
   logic        wr_q;
   logic [1:0]  lane_q;

   logic        dec_known;
   logic        dec_load;
   logic        dec_sign;
   size_t       dec_size;
   logic        dec_ok;
   logic        dec_misal;
   logic [3:0]  dec_be;
   logic [31:0] dec_wdata;

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] ld_ext;

   always_comb begin
      dec_known = 1'b1;
      dec_load  = 1'b0;
      dec_sign  = 1'b0;
      dec_size  = SZ_WORD;
      case (op_ctrl)
         MEM_LB:  begin dec_load = 1'b1; dec_sign = 1'b1; dec_size = SZ_BYTE; end
         MEM_LBU: begin dec_load = 1'b1; dec_size = SZ_BYTE; end
         MEM_LH:  begin dec_load = 1'b1; dec_sign = 1'b1; dec_size = SZ_HALF; end
         MEM_LHU: begin dec_load = 1'b1; dec_size = SZ_HALF; end
         MEM_LW:  begin dec_load = 1'b1; dec_size = SZ_WORD; end
         MEM_SB:  dec_size = SZ_BYTE;
         MEM_SH:  dec_size = SZ_HALF;
         MEM_SW:  dec_size = SZ_WORD;
         default: dec_known = 1'b0;
      endcase
      // An op whose encoded direction disagrees with op_wr is treated like an unknown op.
      dec_ok    = dec_known && (dec_load != op_wr);
      dec_misal = ((dec_size == SZ_HALF) && op_addr[0]) ||
                  ((dec_size == SZ_WORD) && (op_addr[1:0] != 2'b00));
      case (dec_size)
         SZ_BYTE: begin
            dec_be    = 4'b0001 << op_addr[1:0];
            dec_wdata = {4{op_wdata[7:0]}};
         end
         SZ_HALF: begin
            dec_be    = op_addr[1] ? 4'b1100 : 4'b0011;
            dec_wdata = {2{op_wdata[15:0]}};
         end
         default: begin
            dec_be    = 4'b1111;
            dec_wdata = op_wdata;
         end
      endcase
   end

   always_comb begin
      rd_byte = mem_rdata[{lane_q, 3'b000} +: 8];
      rd_half = mem_rdata[{lane_q[1], 4'b0000} +: 16];
      case (size_q)
         SZ_BYTE: ld_ext = {{24{sign_q & rd_byte[7]}}, rd_byte};
         SZ_HALF: ld_ext = {{16{sign_q & rd_half[15]}}, rd_half};
         default: ld_ext = mem_rdata;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
   logic [7:0] wait_cnt;
`else
   assign exc_bus = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         op_ready  <= 1'b1;
         done      <= 1'b0;
         ld_data   <= '0;
         exc_adel  <= 1'b0;
         exc_ades  <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
         size_q    <= SZ_WORD;
         sign_q    <= 1'b0;
         wr_q      <= 1'b0;
         lane_q    <= '0;
`ifdef LSU_TIMEOUT_EN
         exc_bus   <= 1'b0;
         wait_cnt  <= '0;
`endif
      end else begin
         done     <= 1'b0;
         exc_adel <= 1'b0;
         exc_ades <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         exc_bus  <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (op_valid && op_ready) begin
                  op_ready  <= 1'b0;
                  size_q    <= dec_size;
                  sign_q    <= dec_sign;
                  wr_q      <= op_wr;
                  lane_q    <= op_addr[1:0];
                  mem_we    <= op_wr;
                  mem_addr  <= {op_addr[31:2], 2'b00};
                  mem_be    <= dec_be;
                  mem_wdata <= op_wr ? dec_wdata : '0;
                  if (!dec_ok) begin
                     state   <= S_DONE;
                     done    <= 1'b1;
                     ld_data <= '0;
                  end else if (dec_misal) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     ld_data  <= '0;
                     exc_adel <= !op_wr;
                     exc_ades <= op_wr;
                  end else begin
                     state   <= S_BUS;
                     mem_req <= 1'b1;
`ifdef LSU_TIMEOUT_EN
                     wait_cnt <= '0;
`endif
                  end
               end
            end
            S_BUS: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= S_DONE;
                  done    <= 1'b1;
                  ld_data <= wr_q ? '0 : ld_ext;
               end
`ifdef LSU_TIMEOUT_EN
               else if (wait_cnt == WAIT_LAST) begin
                  mem_req <= 1'b0;
                  state   <= S_DONE;
                  done    <= 1'b1;
                  exc_bus <= 1'b1;
                  ld_data <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
`endif
            end
            S_DONE: begin
               state    <= S_IDLE;
               op_ready <= 1'b1;
            end
            default: begin
               state    <= S_IDLE;
               op_ready <= 1'b1;
               mem_req  <= 1'b0;
            end
         endcase
      end
   end

endmodule
